// File: rtl/cam_mode_ctrl_if.sv
// SCCB write request channel between the mode controller and the SCCB master.
// The controller drives req/addr/data; the master answers with a one-cycle ack.
interface cam_mode_ctrl_if;
    logic       sccb_req;
    logic       sccb_ack;
    logic [7:0] sccb_addr;
    logic [7:0] sccb_data;

    modport master (
        output sccb_req,
        output sccb_addr,
        output sccb_data,
        input  sccb_ack
    );

    modport slave (
        input  sccb_req,
        input  sccb_addr,
        input  sccb_data,
        output sccb_ack
    );
endinterface

// File: rtl/cam_mode_ctrl.sv
// Steps the OV7670 output format on each button pulse by writing COM7/COM15,
// then publishes the new mode once both SCCB writes are acknowledged.
module cam_mode_ctrl #(
    parameter int NUM_MODES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pulse_next,
    cam_mode_ctrl_if.master        sccb,
    output logic                   busy,
    output logic [1:0]             mode
);

    localparam logic [7:0] ADDR_COM7  = 8'h12;
    localparam logic [7:0] ADDR_COM15 = 8'h40;
    localparam logic [1:0] LAST_MODE  = 2'(NUM_MODES - 1);

    typedef enum logic [2:0] {
        IDLE,
        W1,
        GAP,
        W2,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] target;
    logic [1:0] target_nxt;
    logic       pend;

    function automatic logic [1:0] step_mode(input logic [1:0] m);
        return (m == LAST_MODE) ? 2'd0 : m + 2'd1;
    endfunction

    function automatic logic [7:0] com7_val(input logic [1:0] m);
        case (m)
            2'd1:    return 8'h00;
            2'd2:    return 8'h06;
            default: return 8'h04;
        endcase
    endfunction

    function automatic logic [7:0] com15_val(input logic [1:0] m);
        case (m)
            2'd1:    return 8'hC0;
            default: return 8'hD0;
        endcase
    endfunction

    // A chained sequence steps from the mode just committed in DONE.
    assign target_nxt = (state == DONE) ? step_mode(target)
                                        : step_mode(mode);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; acks outside W1/W2 are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pulse_next || pend) state_nxt = W1;
            W1:   if (sccb.sccb_ack)      state_nxt = GAP;
            GAP:                          state_nxt = W2;
            W2:   if (sccb.sccb_ack)      state_nxt = DONE;
            DONE: state_nxt = pend ? W1 : IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy          = (state != IDLE);
        sccb.sccb_req = (state == W1) || (state == W2);
    end

    // Mode, target, pending-step flag and the registered SCCB address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode           <= 2'd0;
            target         <= 2'd0;
            pend           <= 1'b0;
            sccb.sccb_addr <= 8'h00;
            sccb.sccb_data <= 8'h00;
        end else begin
            case (state)
                IDLE:    pend <= 1'b0;
                DONE:    pend <= pulse_next;
                default: if (pulse_next) pend <= 1'b1;
            endcase
            if (state_nxt == W1 && state != W1) begin
                target         <= target_nxt;
                sccb.sccb_addr <= ADDR_COM7;
                sccb.sccb_data <= com7_val(target_nxt);
            end
            if (state == GAP) begin
                sccb.sccb_addr <= ADDR_COM15;
                sccb.sccb_data <= com15_val(target);
            end
            if (state == DONE) mode <= target;
        end
    end

endmodule

// File: doc/cam_mode_ctrl.md
# cam_mode_ctrl

Consumes the single-cycle pulses from `debounce_1pulse` (one per button press) and steps the OV7670 output format through a fixed list of modes. On each step it issues two SCCB register writes (COM7, COM15) to the SCCB master over a req/ack handshake. Only after both writes are acknowledged does it update the `mode` output used by the capture/format path. It sits between the button debouncers and the SCCB master in the 80x60 RGB/YUV capture design.

## Interface
- `NUM_MODES`, default 3: number of modes, 2..3; the mode counter wraps at `NUM_MODES-1`.
- `rst` in 1: synchronous, active-high reset.
- `clk` in 1: system clock; all logic is on the rising edge.
- `pulse_next` in 1: one-cycle pulse from `debounce_1pulse`; advance to the next mode.
- `sccb_ack` in 1: one-cycle pulse from the SCCB master; the current write has completed.
- `sccb_req` out 1: write request; held high until `sccb_ack`.
- `sccb_addr` out 8: register address; stable while `sccb_req` is high.
- `sccb_data` out 8: register value; stable while `sccb_req` is high.
- `busy` out 1: a write sequence is in progress.
- `mode` out 2: active mode. 0 = RGB565, 1 = YUV422, 2 = RGB565 with colour-bar test pattern.

## Operation
- Per-mode register values:
  - mode 0: COM7 (0x12) = 0x04, COM15 (0x40) = 0xD0
  - mode 1: COM7 = 0x00, COM15 = 0xC0
  - mode 2: COM7 = 0x06, COM15 = 0xD0
- `target` register holds the mode being programmed. `target = (mode == NUM_MODES-1) ? 0 : mode+1`.
- States:
  - IDLE: `busy`=0. On `pulse_next`, go to W1 and compute `target`.
  - W1: `sccb_req`=1, addr 0x12, data COM7(`target`). On `sccb_ack`, go to GAP.
  - GAP: one cycle with `sccb_req`=0, then go to W2.
  - W2: `sccb_req`=1, addr 0x40, data COM15(`target`). On `sccb_ack`, go to DONE.
  - DONE: one cycle. `mode` <= `target`. If `pend`, clear `pend`, compute a new `target` from the updated `mode`, and go to W1. Otherwise go to IDLE.
- `pend` flag:
  - `pulse_next` in any state other than IDLE sets `pend`.
  - Any number of pulses during a sequence collapse into one step.
- `sccb_ack` outside W1/W2 is ignored.
- `pulse_next` and `sccb_ack` in the same cycle: the ack is processed and the pulse sets `pend`.
- `busy` = 1 in W1, GAP, W2 and DONE.
- `sccb_addr`/`sccb_data` are registered. In IDLE they hold their last value (0x00/0x00 after reset).

## Timing
- Reset values: state IDLE, `mode`=0, `target`=0, `pend`=0, `sccb_req`=0, `sccb_addr`=0x00, `sccb_data`=0x00, `busy`=0.
- Reset has no side effects: no writes are issued after reset, because the camera init sequence already programs mode 0.
- `pulse_next` sampled high at edge n: `busy` and `sccb_req` are high from n+1, with addr/data valid in the same cycle.
- `sccb_ack` high at edge k in W1: `sccb_req`=0 at k+1 (GAP); `sccb_req`=1 with the W2 addr/data at k+2.
- `sccb_ack` high at edge m in W2: DONE at m+1; `mode` is updated and visible at m+2.
  - No pend: `busy`=0 at m+2.
  - Pend: `sccb_req`=1 for the next sequence at m+2 and `busy` stays high.
- Minimum sequence length with an immediate ack: 5 cycles from pulse to `busy` low.
- `rst` mid-sequence (W1/W2): on the next edge `sccb_req` drops to 0, `mode` returns to 0, and `pend` is cleared. The SCCB master must abort on req deassertion.
- `mode` never changes while `busy`=0, except on reset.

## Test plan
- Reset, then 20 idle cycles → `sccb_req` never rises; `mode`=0; `busy`=0.
- One pulse with ack 3 cycles after each req → writes (0x12,0x00) then (0x40,0xC0); `mode`=1 exactly 2 cycles after the second ack; `busy` low on the same cycle.
- Three single pulses, each fully acked, starting from mode 0 → `mode` sequence 1, 2, 0 (wrap); the third sequence writes (0x12,0x04), (0x40,0xD0).
- Three pulses during one sequence → exactly two sequences (4 writes) in total; final `mode`=2; `busy` stays high between the sequences.
- `pulse_next` coincident with the W1 ack → GAP/W2 proceed normally and a second sequence follows; a stray `sccb_ack` in IDLE causes no change.
- `rst` asserted while in W2 → next cycle `sccb_req`=0, `mode`=0, `busy`=0, and no further writes.
